// File: rtl/csr_pkg.sv
// Shared CSR index map, op encodings, bit positions and reset constants.
// Used by csr_regfile and csr_counter64.
package csr_pkg;

  localparam logic [4:0] CSR_NONE          = 5'h00;
  localparam logic [4:0] CSR_MVENDORID     = 5'h01;
  localparam logic [4:0] CSR_MARCHID       = 5'h02;
  localparam logic [4:0] CSR_MIMPID        = 5'h03;
  localparam logic [4:0] CSR_MHARTID       = 5'h04;
  localparam logic [4:0] CSR_MSTATUS       = 5'h05;
  localparam logic [4:0] CSR_MISA          = 5'h06;
  localparam logic [4:0] CSR_MIE           = 5'h07;
  localparam logic [4:0] CSR_MTVEC         = 5'h08;
  localparam logic [4:0] CSR_MSTATUSH      = 5'h09;
  localparam logic [4:0] CSR_MSCRATCH      = 5'h0A;
  localparam logic [4:0] CSR_MEPC          = 5'h0B;
  localparam logic [4:0] CSR_MCAUSE        = 5'h0C;
  localparam logic [4:0] CSR_MTVAL         = 5'h0D;
  localparam logic [4:0] CSR_MIP           = 5'h0E;
  localparam logic [4:0] CSR_MCYCLE        = 5'h0F;
  localparam logic [4:0] CSR_MINSTRET      = 5'h10;
  localparam logic [4:0] CSR_MHPMCOUNTER3  = 5'h11;
  localparam logic [4:0] CSR_MCYCLEH       = 5'h12;
  localparam logic [4:0] CSR_MINSTRETH     = 5'h13;
  localparam logic [4:0] CSR_MHPMCOUNTER3H = 5'h14;
  localparam logic [4:0] CSR_MCOUNTINHIBIT = 5'h15;
  localparam logic [4:0] CSR_MHPMEVENT3    = 5'h16;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [1:0]  MSTATUS_MPP_M = 2'b11;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
  localparam logic [31:0] MTVEC_MASK    = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK     = 32'hFFFF_FFFC;
  localparam logic [31:0] CSR_RST_VAL   = 32'h0000_0000;
  localparam logic [63:0] CNT_RST_VAL   = 64'h0;

  localparam logic [31:0] MCNTINH_MASK_BASE = 32'h0000_0005;
  localparam logic [31:0] MCNTINH_MASK_HPM  = 32'h0000_000D;

  localparam logic [31:0] HPM_EV_CYCLES  = 32'd1;
  localparam logic [31:0] HPM_EV_INSTRET = 32'd2;

  function automatic logic [31:0] csr_apply(
    input csr_op_e     op,
    input logic [31:0] old,
    input logic [31:0] wdata
  );
    logic [31:0] res;
    res = old;
    unique case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old | wdata;
      CSR_OP_RC: res = old & ~wdata;
      default:   res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with per-half write; a write suppresses the increment.
// Wraps from all-ones to zero.
module csr_counter64
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo) begin
      cnt_d[31:0] = wdata;
    end else if (wr_hi) begin
      cnt_d[63:32] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: CSRRW/S/C access, trap/mret state, counters.
// Optional HPM counter 3 enabled by defining CSR_HPM_EN.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  csr_index,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        irq_pending
);

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mcntinh_q, mcntinh_d;
  logic [31:0] mhpmevent3;

  logic [63:0] mcycle_val;
  logic [63:0] minstret_val;
  logic [63:0] hpm_val;

  logic [31:0] mstatus_rd;
  logic [31:0] mip_rd;
  logic        is_ro;
  logic        wr_intent;
  logic        wr_en;
  logic [31:0] wr_val;

  assign mstatus_rd = {19'b0, MSTATUS_MPP_M, 3'b0, mst_mpie_q,
                       3'b0, mst_mie_q, 3'b0};

  assign mip_rd = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_index)
      CSR_MHARTID:       csr_rdata = HART_ID;
      CSR_MSTATUS:       csr_rdata = mstatus_rd;
      CSR_MISA:          csr_rdata = MISA_VAL;
      CSR_MIE:           csr_rdata = mie_q;
      CSR_MTVEC:         csr_rdata = mtvec_q;
      CSR_MSCRATCH:      csr_rdata = mscratch_q;
      CSR_MEPC:          csr_rdata = mepc_q;
      CSR_MCAUSE:        csr_rdata = mcause_q;
      CSR_MTVAL:         csr_rdata = mtval_q;
      CSR_MIP:           csr_rdata = mip_rd;
      CSR_MCYCLE:        csr_rdata = mcycle_val[31:0];
      CSR_MINSTRET:      csr_rdata = minstret_val[31:0];
      CSR_MHPMCOUNTER3:  csr_rdata = hpm_val[31:0];
      CSR_MCYCLEH:       csr_rdata = mcycle_val[63:32];
      CSR_MINSTRETH:     csr_rdata = minstret_val[63:32];
      CSR_MHPMCOUNTER3H: csr_rdata = hpm_val[63:32];
      CSR_MCOUNTINHIBIT: csr_rdata = mcntinh_q;
      CSR_MHPMEVENT3:    csr_rdata = mhpmevent3;
      default:           csr_rdata = 32'h0;
    endcase
  end

  assign is_ro = (csr_index == CSR_MVENDORID) || (csr_index == CSR_MARCHID)
              || (csr_index == CSR_MIMPID) || (csr_index == CSR_MHARTID)
              || (csr_index == CSR_MISA);

  assign wr_intent = (op == CSR_OP_RW)
                  || (((op == CSR_OP_RS) || (op == CSR_OP_RC))
                      && (csr_wdata != 32'h0));

  assign csr_illegal = (op != CSR_OP_NONE)
                    && ((csr_index == CSR_NONE) || (wr_intent && is_ro));

  // Trap and mret take the cycle; a coincident CSR write is dropped.
  assign wr_en  = wr_intent && !csr_illegal && !trap_valid && !mret_valid;
  assign wr_val = csr_apply(op, csr_rdata, csr_wdata);

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
  logic wr_mepc, wr_mcause, wr_mtval, wr_mcntinh;

  assign wr_mstatus  = wr_en && (csr_index == CSR_MSTATUS);
  assign wr_mie      = wr_en && (csr_index == CSR_MIE);
  assign wr_mtvec    = wr_en && (csr_index == CSR_MTVEC);
  assign wr_mscratch = wr_en && (csr_index == CSR_MSCRATCH);
  assign wr_mepc     = wr_en && (csr_index == CSR_MEPC);
  assign wr_mcause   = wr_en && (csr_index == CSR_MCAUSE);
  assign wr_mtval    = wr_en && (csr_index == CSR_MTVAL);
  assign wr_mcntinh  = wr_en && (csr_index == CSR_MCOUNTINHIBIT);

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcntinh_d  = mcntinh_q;
    if (trap_valid) begin
      mepc_d     = trap_pc & MEPC_MASK;
      mcause_d   = trap_cause;
      mtval_d    = trap_tval;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_valid) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else begin
      if (wr_mstatus) begin
        mst_mie_d  = wr_val[MSTATUS_MIE];
        mst_mpie_d = wr_val[MSTATUS_MPIE];
      end
      if (wr_mie)      mie_d      = wr_val & MIE_MASK;
      if (wr_mtvec)    mtvec_d    = wr_val & MTVEC_MASK;
      if (wr_mscratch) mscratch_d = wr_val;
      if (wr_mepc)     mepc_d     = wr_val & MEPC_MASK;
      if (wr_mcause)   mcause_d   = wr_val;
      if (wr_mtval)    mtval_d    = wr_val;
`ifdef CSR_HPM_EN
      if (wr_mcntinh)  mcntinh_d  = wr_val & MCNTINH_MASK_HPM;
`else
      if (wr_mcntinh)  mcntinh_d  = wr_val & MCNTINH_MASK_BASE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= CSR_RST_VAL;
      mtvec_q    <= CSR_RST_VAL;
      mscratch_q <= CSR_RST_VAL;
      mepc_q     <= CSR_RST_VAL;
      mcause_q   <= CSR_RST_VAL;
      mtval_q    <= CSR_RST_VAL;
      mcntinh_q  <= CSR_RST_VAL;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcntinh_q  <= mcntinh_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!mcntinh_q[0]),
    .wr_lo (wr_en && (csr_index == CSR_MCYCLE)),
    .wr_hi (wr_en && (csr_index == CSR_MCYCLEH)),
    .wdata (wr_val),
    .value (mcycle_val)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instr_retire && !mcntinh_q[2]),
    .wr_lo (wr_en && (csr_index == CSR_MINSTRET)),
    .wr_hi (wr_en && (csr_index == CSR_MINSTRETH)),
    .wdata (wr_val),
    .value (minstret_val)
  );

`ifdef CSR_HPM_EN
  logic [31:0] mhpmevent3_q, mhpmevent3_d;
  logic        hpm_evt;

  always_comb begin
    mhpmevent3_d = mhpmevent3_q;
    if (wr_en && (csr_index == CSR_MHPMEVENT3)) mhpmevent3_d = wr_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mhpmevent3_q <= CSR_RST_VAL;
    end else begin
      mhpmevent3_q <= mhpmevent3_d;
    end
  end

  assign hpm_evt = (mhpmevent3_q == HPM_EV_CYCLES)
                || ((mhpmevent3_q == HPM_EV_INSTRET) && instr_retire);

  csr_counter64 u_mhpm3 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hpm_evt && !mcntinh_q[3]),
    .wr_lo (wr_en && (csr_index == CSR_MHPMCOUNTER3)),
    .wr_hi (wr_en && (csr_index == CSR_MHPMCOUNTER3H)),
    .wdata (wr_val),
    .value (hpm_val)
  );

  assign mhpmevent3 = mhpmevent3_q;
`else
  assign hpm_val    = 64'h0;
  assign mhpmevent3 = 32'h0;
`endif

  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;
  assign irq_pending = mst_mie_q && ((mie_q & mip_rd) != 32'h0);

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR register file for the RV32 core, directly downstream of the CSR address translator. Consumes the 5-bit `csr_index` that the translator produces, performs CSRRW/CSRRS/CSRRC reads and writes, and holds the trap state. It also maintains the 64-bit cycle, instret and optional HPM counters, and produces the interrupt-pending signal and trap vector/return addresses for the core.

## Interface
- `HART_ID`, 0: value returned by mhartid.
- `MISA_VAL`, 32'h4000_0100: value returned by misa (RV32I).
- `clk`  in  1  core clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `csr_index`  in  5  translated CSR index; 0 means unmapped.
- `csr_op`  in  2  operation: 00 none, 01 RW, 10 RS, 11 RC.
- `csr_wdata`  in  32  write operand (rs1 value or zimm).
- `csr_rdata`  out  32  old CSR value, combinational.
- `csr_illegal`  out  1  illegal access this cycle, combinational.
- `instr_retire`  in  1  one instruction retired this cycle.
- `trap_valid`  in  1  trap taken this cycle.
- `trap_cause`  in  32  mcause value for the trap.
- `trap_pc`  in  32  PC of the faulting or interrupted instruction.
- `trap_tval`  in  32  mtval value for the trap.
- `mret_valid`  in  1  MRET executes this cycle.
- `irq_sw`, `irq_timer`, `irq_ext`  in  1 each  level interrupt lines.
- `mtvec_out`  out  32  current mtvec.
- `mepc_out`  out  32  current mepc.
- `irq_pending`  out  1  mstatus.MIE & |(mie & mip).

## Operation
- Index map:
  - 01..04: mvendorid, marchid, mimpid, mhartid. Read-only; the first three read 0.
  - 05 mstatus, 06 misa (read-only), 07 mie, 08 mtvec, 09 mstatush (reads 0), 0A mscratch, 0B mepc, 0C mcause, 0D mtval, 0E mip.
  - 0F mcycle, 10 minstret, 11 mhpmcounter3, 12 mcycleh, 13 minstreth, 14 mhpmcounter3h, 15 mcountinhibit, 16 mhpmevent3.
- Write intent:
  - RW always writes.
  - RS/RC write only when csr_wdata != 0.
  - New value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
- csr_illegal is asserted when op != 00 and either (index == 0) or (write intent and the CSR is read-only). When illegal, no state changes. rdata is still driven, and reads 0 for index 0.
- mstatus:
  - Only MIE[3] and MPIE[7] are writable.
  - MPP[12:11] is hardwired 2'b11; all other bits read 0.
- mie: bits 3, 7, 11 writable; others read 0.
- mip: bits 3/7/11 reflect irq_sw/irq_timer/irq_ext directly. Writes are ignored, and writing mip is not illegal.
- mtvec: bit 1 is hardwired 0 (modes direct/vectored only).
- mepc: bits [1:0] are hardwired 0, including on trap capture.
- Trap, when trap_valid:
  - mepc <= trap_pc, mcause <= trap_cause, mtval <= trap_tval.
  - MPIE <= MIE, MIE <= 0.
- MRET, when mret_valid: MIE <= MPIE, MPIE <= 1.
- Priority: trap > mret > CSR write. A lower-priority event in the same cycle is dropped entirely. csr_illegal is still computed normally.
- Counters (64-bit):
  - mcycle increments every cycle unless mcountinhibit[0] is set.
  - minstret increments on instr_retire unless mcountinhibit[2] is set.
  - Wrap from 2^64-1 to 0.
  - A CSR write to either half replaces that half. The counter's increment is suppressed in that cycle; the other half is held.
- mcountinhibit: bits 0 and 2 writable (and bit 3, see Configuration); the rest read 0.

## Timing
- Reads are combinational, in the same cycle as csr_index/csr_op.
- Writes, trap and mret updates are visible on rdata and outputs the cycle after the edge.
- A counter read returns the pre-increment value of the current cycle.
- irq_pending is combinational from registered mstatus/mie and the live irq lines.
- Reset values:
  - mstatus: MIE=0, MPIE=0 (reads 32'h0000_1800).
  - mie, mtvec, mscratch, mepc, mcause, mtval: 0.
  - All counters, mcountinhibit and mhpmevent3: 0.
  - Outputs: irq_pending=0, mtvec_out=0, mepc_out=0.
- Reset asserted mid-operation overrides any trap, mret or write in that cycle.

## Configuration
- `CSR_HPM_EN` defined:
  - mhpmcounter3/h, mhpmevent3 and mcountinhibit[3] are implemented.
  - mhpmevent3 selects the counting event: 1 = cycles, 2 = retired instructions, other values = none.
  - mhpmcounter3 follows the same write/wrap rules as the other counters; mcountinhibit[3] inhibits it.
- `CSR_HPM_EN` undefined:
  - Indices 11, 14, 16 read 0; writes are ignored and not illegal.
  - mcountinhibit[3] reads 0.

## Structure
- Shared package `csr_pkg`:
  - CSR index localparams 01..16.
  - csr_op encodings.
  - mstatus/mip/mie bit positions.
  - Reset constants and the hardwired MPP value.
- Sub-module `csr_counter64`:
  - Ports: clk, rst_n, inc, wr_lo, wr_hi, wdata, value[63:0].
  - Instantiated for mcycle, minstret and (under CSR_HPM_EN) mhpmcounter3.

## Test plan
- Reset, then read index 05 -> rdata=32'h0000_1800, irq_pending=0.
- RW mie=32'h888; RS mstatus wdata=8; raise irq_timer -> next cycle irq_pending=1; RC mstatus wdata=8 -> irq_pending=0.
- Write index 06 with RW 32'h1 -> csr_illegal=1, misa unchanged. RS index 06 wdata=0 -> csr_illegal=0. Index 0 with op RW -> illegal.
- MIE=1; trap_valid with trap_pc=32'h0000_1236, cause 32'h8000_000B, plus a simultaneous RW mscratch -> mepc=32'h1234, mcause set, MIE=0, MPIE=1, mscratch unchanged. mret next -> MIE=1, MPIE=1.
- RW mcycle=32'hFFFF_FFFF, mcycleh=32'hFFFF_FFFF, then 2 free cycles -> mcycleh reads 0, mcycle reads 0 then 1 (wrap). Set mcountinhibit=1 -> mcycle frozen.
- With CSR_HPM_EN: mhpmevent3=2, pulse instr_retire 3 times -> mhpmcounter3=3. Without it: index 11 reads 0 after RW 5, csr_illegal=0.
